// File: rtl/eeg_crypto_scheduler.sv
// eeg_crypto_scheduler
//   Round-robin arbiter and start/flush sequencer in front of one shared
//   AES-256-GCM eeg_data_encryptor. A granted requester holds gnt from LAUNCH
//   until its response handshake. The scheduler issues the encrypt/decrypt start
//   pulses, flushes a stale CAPTURE/ERROR state first, and returns a status
//   response.
//   Optional feature macro: EEG_SCHED_TIMEOUT_EN adds a WAIT watchdog. A timeout
//   is reported as rsp_timeout, sets a sticky fault, and parks the block in FAULT
//   until reset.
module eeg_crypto_scheduler #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_op,
  output logic [N_REQ-1:0]         gnt,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic                     rsp_ok,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic                     enc_encrypt_start,
  output logic                     enc_decrypt_start,
  output logic                     enc_nonce_increment,
  input  logic                     enc_busy,
  input  logic                     enc_done,
  input  logic                     enc_error,
  output logic                     sched_busy,
  output logic                     fault
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] GNT_ONE = N_REQ'(1);

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("eeg_crypto_scheduler: N_REQ must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_FLUSH  = 3'd2,
    S_DRAIN  = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_nxt;
  logic [IDX_W-1:0]   win_idx, win_nxt;
  logic               win_op, op_nxt;
  logic [N_REQ-1:0]   gnt_nxt;
  logic               valid_nxt, ok_nxt, err_nxt, tmo_nxt;
  logic               enc_start_nxt, dec_start_nxt;
  logic               fault_nxt;
  logic               first_wait, first_nxt;
  logic               tmo_hit;

  logic               found;
  logic [IDX_W-1:0]   win_sel;
  logic [IDX_W:0]     cand_sum;
  logic [IDX_W-1:0]   cand;

  // Advance a requester index by one, wrapping at N_REQ-1.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(N_REQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

  assign rsp_id     = win_idx;
  assign sched_busy = (state != S_IDLE);

  // The nonce advances in the accepting cycle of a successful encrypt only.
  assign enc_nonce_increment = (state == S_RESP) && rsp_ready && !win_op && rsp_ok;

`ifdef EEG_SCHED_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  assign tmo_hit = (state == S_WAIT) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: held at zero outside WAIT, so every WAIT entry starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != S_WAIT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Round-robin search: first set request at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found    = 1'b0;
    win_sel  = '0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand_sum >= (IDX_W+1)'(N_REQ)) cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
      cand = cand_sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_sel = cand;
      end
    end
  end

  // Next-state and next-output logic. Every registered output holds its value by
  // default. The start pulses default low, so each pulse lasts one cycle.
  always_comb begin
    state_nxt     = state;
    rr_nxt        = rr_ptr;
    win_nxt       = win_idx;
    op_nxt        = win_op;
    gnt_nxt       = gnt;
    valid_nxt     = rsp_valid;
    ok_nxt        = rsp_ok;
    err_nxt       = rsp_err;
    tmo_nxt       = rsp_timeout;
    enc_start_nxt = 1'b0;
    dec_start_nxt = 1'b0;
    fault_nxt     = fault;
    first_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (found && !fault) begin
          win_nxt   = win_sel;
          op_nxt    = req_op[win_sel];
          gnt_nxt   = GNT_ONE << win_sel;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!enc_busy) begin
          enc_start_nxt = !win_op;
          dec_start_nxt = win_op;
          first_nxt     = 1'b1;
          state_nxt     = S_WAIT;
        end else if (enc_done || enc_error) begin
          // Encryptor still parked in CAPTURE/ERROR from the previous op: a start
          // pulse returns it to IDLE before the real launch.
          enc_start_nxt = !win_op;
          dec_start_nxt = win_op;
          state_nxt     = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!enc_busy) state_nxt = S_LAUNCH;
      end
      S_WAIT: begin
        // done/error still reflect the previous op during the start-pulse cycle.
        if (!first_wait && (enc_done || enc_error)) begin
          valid_nxt = 1'b1;
          ok_nxt    = !enc_error;
          err_nxt   = enc_error;
          tmo_nxt   = 1'b0;
          state_nxt = S_RESP;
        end else if (tmo_hit) begin
          valid_nxt = 1'b1;
          ok_nxt    = 1'b0;
          err_nxt   = 1'b0;
          tmo_nxt   = 1'b1;
          fault_nxt = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          valid_nxt = 1'b0;
          ok_nxt    = 1'b0;
          err_nxt   = 1'b0;
          tmo_nxt   = 1'b0;
          gnt_nxt   = '0;
          rr_nxt    = next_idx(win_idx);
          state_nxt = fault ? S_FAULT : S_IDLE;
        end
      end
      S_FAULT: begin
        gnt_nxt = '0;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      rr_ptr            <= '0;
      win_idx           <= '0;
      win_op            <= 1'b0;
      gnt               <= '0;
      rsp_valid         <= 1'b0;
      rsp_ok            <= 1'b0;
      rsp_err           <= 1'b0;
      rsp_timeout       <= 1'b0;
      enc_encrypt_start <= 1'b0;
      enc_decrypt_start <= 1'b0;
      fault             <= 1'b0;
      first_wait        <= 1'b0;
    end else begin
      state             <= state_nxt;
      rr_ptr            <= rr_nxt;
      win_idx           <= win_nxt;
      win_op            <= op_nxt;
      gnt               <= gnt_nxt;
      rsp_valid         <= valid_nxt;
      rsp_ok            <= ok_nxt;
      rsp_err           <= err_nxt;
      rsp_timeout       <= tmo_nxt;
      enc_encrypt_start <= enc_start_nxt;
      enc_decrypt_start <= dec_start_nxt;
      fault             <= fault_nxt;
      first_wait        <= first_nxt;
    end
  end

endmodule
